// File: rtl/safe_pin_ctrl.sv
// safe_pin_ctrl
//   PIN-protected safe controller. A multi-digit PIN is entered one digit at a
//   time on slide switches and committed with a push button. While the safe is
//   open, the PIN can be changed. Repeated failures lock entry out for a fixed
//   number of cycles. The vault status gates everything: a closed vault forces
//   IDLE. Both push buttons are synchronised and debounced on Clk.
//
// Ports
//   Clk              system clock
//   Reset            asynchronous, active-high
//   vault_open       1 = vault open, 0 forces IDLE
//   pin_digit        switch value captured on each digit press
//   open_close_push  raw button: capture digit / request close
//   pin_change_push  raw button: start or abort PIN change, abort entry
//   safe_open        1 in OPEN or NEWPIN
//   invalid          last operation rejected
//   locked           lockout timer nonzero
//   fail_count       consecutive failed attempts
//   digit_idx        digits captured in the current entry
//   state            IDLE=0 CLOSED=1 ENTRY=2 OPEN=3 NEWPIN=4 LOCKOUT=5
//   pin_stored       current PIN, digit 0 in the most significant position
module safe_pin_ctrl #(
  parameter int PIN_W           = 4,
  parameter int PIN_DIGITS      = 4,
  parameter logic [PIN_W*PIN_DIGITS-1:0] DEFAULT_PIN = 16'h1234,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 1024,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                vault_open,
  input  logic [PIN_W-1:0]                    pin_digit,
  input  logic                                open_close_push,
  input  logic                                pin_change_push,
  output logic                                safe_open,
  output logic                                invalid,
  output logic                                locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]      fail_count,
  output logic [$clog2(PIN_DIGITS+1)-1:0]     digit_idx,
  output logic [2:0]                          state,
  output logic [PIN_W*PIN_DIGITS-1:0]         pin_stored
);

  localparam int PIN_BITS = PIN_W * PIN_DIGITS;
  localparam int FC_W     = $clog2(MAX_FAILS + 1);
  localparam int IDX_W    = $clog2(PIN_DIGITS + 1);
  localparam int TMR_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLOSED  = 3'd1,
    ENTRY   = 3'd2,
    OPEN    = 3'd3,
    NEWPIN  = 3'd4,
    LOCKOUT = 3'd5
  } stateT;

  // Digit idx of a packed PIN; digit 0 sits in the most significant slot.
  function automatic logic [PIN_W-1:0] digitAt(input logic [PIN_BITS-1:0] pin,
                                               input logic [IDX_W-1:0] idx);
    logic [PIN_W-1:0] d;
    d = '0;
    for (int i = 0; i < PIN_DIGITS; i++) begin
      if (idx == IDX_W'(i)) d = pin[(PIN_DIGITS-1-i)*PIN_W +: PIN_W];
    end
    return d;
  endfunction

  // Failure counter increment, saturating at MAX_FAILS.
  function automatic logic [FC_W-1:0] satInc(input logic [FC_W-1:0] v);
    return (v >= FC_W'(MAX_FAILS)) ? FC_W'(MAX_FAILS) : v + FC_W'(1);
  endfunction

  // ---- Button conditioning: bit 0 = open_close, bit 1 = pin_change --------
  logic [1:0]       btnRaw;
  logic [1:0]       btnSync_p0;
  logic [1:0]       btnSync_p1;
  logic [1:0]       btnLevel;
  logic [1:0]       btnPress;
  logic [CNT_W-1:0] dbCnt [2];
  logic             ocPress;
  logic             pcPress;

  assign btnRaw  = {pin_change_push, open_close_push};
  assign ocPress = btnPress[0];
  assign pcPress = btnPress[1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btnSync_p0 <= '0;
      btnSync_p1 <= '0;
      btnLevel   <= '0;
      btnPress   <= '0;
      for (int b = 0; b < 2; b++) dbCnt[b] <= '0;
    end else begin
      // stage p0/p1: two-flop synchroniser
      btnSync_p0 <= btnRaw;
      btnSync_p1 <= btnSync_p0;
      // debounce: level flips only after DEBOUNCE_CYCLES consecutive differing
      // samples; only the rising flip produces a press pulse
      for (int b = 0; b < 2; b++) begin
        btnPress[b] <= 1'b0;
        if (btnSync_p1[b] == btnLevel[b]) begin
          dbCnt[b] <= '0;
        end else if (dbCnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          dbCnt[b]    <= '0;
          btnLevel[b] <= btnSync_p1[b];
          btnPress[b] <= btnSync_p1[b];
        end else begin
          dbCnt[b] <= dbCnt[b] + CNT_W'(1);
        end
      end
    end
  end

  // ---- Controller --------------------------------------------------------
  stateT               st;
  logic [PIN_BITS-1:0] shadow;
  logic [TMR_W-1:0]    timer;
  logic                mism;

  logic [IDX_W-1:0]    cmpIdx;
  logic [PIN_W-1:0]    refDigit;
  logic                attemptBad;
  logic                attemptLast;
  logic [FC_W-1:0]     failNext;
  logic [PIN_BITS-1:0] shadowNext;

  assign state = st;

  always_comb begin
    // The CLOSED capture is always digit 0; in ENTRY the index is live.
    cmpIdx      = (st == ENTRY) ? digit_idx : '0;
    refDigit    = digitAt(pin_stored, cmpIdx);
    attemptBad  = (pin_digit != refDigit) || ((st == ENTRY) && mism);
    attemptLast = (cmpIdx == IDX_W'(PIN_DIGITS - 1));
    failNext    = satInc(fail_count);
    shadowNext  = shadow;
    for (int i = 0; i < PIN_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) shadowNext[(PIN_DIGITS-1-i)*PIN_W +: PIN_W] = pin_digit;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st         <= IDLE;
      safe_open  <= 1'b0;
      invalid    <= 1'b0;
      locked     <= 1'b0;
      fail_count <= '0;
      digit_idx  <= '0;
      pin_stored <= DEFAULT_PIN;
      shadow     <= '0;
      timer      <= '0;
      mism       <= 1'b0;
    end else begin
      // Lockout timer runs in every state so closing the vault cannot pause it.
      // locked tracks the value the timer holds after this edge.
      if (timer != '0) timer <= timer - TMR_W'(1);
      locked <= (timer > TMR_W'(1));
      if (timer == TMR_W'(1)) fail_count <= '0;

      if (!vault_open) begin
        st        <= IDLE;
        safe_open <= 1'b0;
        invalid   <= 1'b0;
        digit_idx <= '0;
        mism      <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            st <= (timer > TMR_W'(1)) ? LOCKOUT : CLOSED;
          end

          // CLOSED makes the first capture; ENTRY continues the attempt.
          CLOSED, ENTRY: begin
            if ((st == ENTRY) && pcPress) begin
              st        <= CLOSED;
              digit_idx <= '0;
              mism      <= 1'b0;
            end else if (ocPress) begin
              if (attemptLast) begin
                digit_idx <= '0;
                mism      <= 1'b0;
                if (!attemptBad) begin
                  st         <= OPEN;
                  safe_open  <= 1'b1;
                  invalid    <= 1'b0;
                  fail_count <= '0;
                end else begin
                  invalid    <= 1'b1;
                  fail_count <= failNext;
                  if (failNext == FC_W'(MAX_FAILS)) begin
                    st     <= LOCKOUT;
                    timer  <= TMR_W'(LOCKOUT_CYCLES);
                    locked <= 1'b1;
                  end else begin
                    st <= CLOSED;
                  end
                end
              end else begin
                st        <= ENTRY;
                digit_idx <= digit_idx + IDX_W'(1);
                mism      <= attemptBad;
                invalid   <= 1'b0;
              end
            end
          end

          OPEN: begin
            if (pcPress) begin
              st        <= NEWPIN;
              digit_idx <= '0;
            end else if (ocPress) begin
              // Closing requires the switches parked at zero.
              if (pin_digit == '0) begin
                st        <= CLOSED;
                safe_open <= 1'b0;
                invalid   <= 1'b0;
              end else begin
                invalid <= 1'b1;
              end
            end
          end

          NEWPIN: begin
            if (pcPress) begin
              st        <= OPEN;
              digit_idx <= '0;
            end else if (ocPress) begin
              shadow <= shadowNext;
              if (digit_idx == IDX_W'(PIN_DIGITS - 1)) begin
                pin_stored <= shadowNext;
                invalid    <= 1'b0;
                st         <= OPEN;
                digit_idx  <= '0;
              end else begin
                digit_idx <= digit_idx + IDX_W'(1);
              end
            end
          end

          LOCKOUT: begin
            if (timer <= TMR_W'(1)) st <= CLOSED;
          end

          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_safe_pin_ctrl.sv
// tb_safe_pin_ctrl
//   Self-checking bench for safe_pin_ctrl (DEBOUNCE_CYCLES=4,
//   LOCKOUT_CYCLES=64, other parameters default). Expected output snapshots
//   are queued as each stimulus is driven and compared as the DUT responds.
module tb_safe_pin_ctrl;

  localparam int DB  = 4;
  localparam int LCK = 64;
  localparam logic [15:0] P0 = 16'h1234;
  localparam logic [15:0] P1 = 16'h9876;

  logic        Clk;
  logic        Reset;
  logic        vault_open;
  logic [3:0]  pin_digit;
  logic        open_close_push;
  logic        pin_change_push;
  logic        safe_open;
  logic        invalid;
  logic        locked;
  logic [1:0]  fail_count;
  logic [2:0]  digit_idx;
  logic [2:0]  state;
  logic [15:0] pin_stored;

  safe_pin_ctrl #(
    .LOCKOUT_CYCLES (LCK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .vault_open     (vault_open),
    .pin_digit      (pin_digit),
    .open_close_push(open_close_push),
    .pin_change_push(pin_change_push),
    .safe_open      (safe_open),
    .invalid        (invalid),
    .locked         (locked),
    .fail_count     (fail_count),
    .digit_idx      (digit_idx),
    .state          (state),
    .pin_stored     (pin_stored)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [26:0] snap;
  assign snap = {state, safe_open, invalid, locked, fail_count, digit_idx, pin_stored};

  typedef struct {
    string       tag;
    logic [26:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [26:0] respQ[$];
  exp_t        e;
  logic [26:0] r;
  logic [26:0] resp;
  int          respCyc;
  int          lockCyc;
  int          fallCyc;
  int          nRun = 0;
  int          nFail = 0;

  function automatic logic [26:0] mk(input int st, input bit so, input bit inv, input bit lk,
                                     input int fc, input int di, input logic [15:0] pin);
    return {st[2:0], so, inv, lk, fc[1:0], di[2:0], pin};
  endfunction

  function automatic exp_t ex(input string tag, input logic [26:0] v);
    exp_t t;
    t.tag = tag;
    t.val = v;
    return t;
  endfunction

  // Clean press: hold until the response edge, sample, then release and settle.
  task automatic press(input bit oc, input bit pc, input logic [3:0] d);
    @(negedge Clk);
    pin_digit       = d;
    open_close_push = oc;
    pin_change_push = pc;
    repeat (DB + 3) @(posedge Clk);
    #1;
    resp    = snap;
    respCyc = cyc;
    @(negedge Clk);
    open_close_push = 1'b0;
    pin_change_push = 1'b0;
    repeat (DB + 4) @(negedge Clk);
  endtask

  task automatic step(input string tag, input bit oc, input bit pc, input logic [3:0] d,
                      input logic [26:0] v);
    sb.push_back(ex(tag, v));
    press(oc, pc, d);
    respQ.push_back(resp);
  endtask

  task automatic waitUnlock();
    fallCyc = -100000;
    for (int i = 0; i < 4 * LCK; i++) begin
      @(posedge Clk);
      #1;
      if (!locked) begin
        fallCyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; vault_open = 1'b0; pin_digit = '0;
    open_close_push = 1'b0; pin_change_push = 1'b0;
    repeat (3) @(negedge Clk);
    sb.push_back(ex("reset_vals", mk(0, 0, 0, 0, 0, 0, P0)));
    respQ.push_back(snap);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    sb.push_back(ex("idle_vault_closed", mk(0, 0, 0, 0, 0, 0, P0)));
    respQ.push_back(snap);
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  task automatic test_correct_entry();
    @(negedge Clk);
    vault_open = 1'b1;
    @(posedge Clk); #1;
    sb.push_back(ex("vault_open_closed", mk(1, 0, 0, 0, 0, 0, P0)));
    respQ.push_back(snap);
    step("entry_d1", 1, 0, 4'd1, mk(2, 0, 0, 0, 0, 1, P0));
    step("entry_d2", 1, 0, 4'd2, mk(2, 0, 0, 0, 0, 2, P0));
    step("entry_d3", 1, 0, 4'd3, mk(2, 0, 0, 0, 0, 3, P0));
    step("entry_open", 1, 0, 4'd4, mk(3, 1, 0, 0, 0, 0, P0));
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  task automatic test_close_rules();
    step("close_nonzero", 1, 0, 4'd5, mk(3, 1, 1, 0, 0, 0, P0));
    step("newpin_enter", 0, 1, 4'd0, mk(4, 1, 1, 0, 0, 0, P0));
    step("newpin_d1", 1, 0, 4'd9, mk(4, 1, 1, 0, 0, 1, P0));
    step("newpin_d2", 1, 0, 4'd8, mk(4, 1, 1, 0, 0, 2, P0));
    step("newpin_abort", 0, 1, 4'd0, mk(3, 1, 1, 0, 0, 0, P0));
    step("close_zero", 1, 0, 4'd0, mk(1, 0, 0, 0, 0, 0, P0));
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  task automatic test_bounce_lockout();
    @(negedge Clk);
    open_close_push = 1'b1;
    repeat (2) @(negedge Clk);
    open_close_push = 1'b0;
    repeat (12) @(negedge Clk);
    sb.push_back(ex("glitch_ignored", mk(1, 0, 0, 0, 0, 0, P0)));
    respQ.push_back(snap);
    for (int a = 1; a <= 3; a++) begin
      step($sformatf("fail%0d_d1", a), 1, 0, 4'd1, mk(2, 0, 0, 0, a - 1, 1, P0));
      step($sformatf("fail%0d_d2", a), 1, 0, 4'd2, mk(2, 0, 0, 0, a - 1, 2, P0));
      step($sformatf("fail%0d_d3", a), 1, 0, 4'd3, mk(2, 0, 0, 0, a - 1, 3, P0));
      step($sformatf("fail%0d_end", a), 1, 0, 4'd5,
           (a < 3) ? mk(1, 0, 1, 0, a, 0, P0) : mk(5, 0, 1, 1, 3, 0, P0));
    end
    lockCyc = respCyc;
    waitUnlock();
    sb.push_back(ex("lockout_len", 27'(LCK)));
    respQ.push_back(27'(fallCyc - lockCyc));
    sb.push_back(ex("lockout_exit", mk(1, 0, 1, 0, 0, 0, P0)));
    respQ.push_back(snap);
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  task automatic test_pin_change();
    step("reopen_d1", 1, 0, 4'd1, mk(2, 0, 0, 0, 0, 1, P0));
    step("reopen_d2", 1, 0, 4'd2, mk(2, 0, 0, 0, 0, 2, P0));
    step("reopen_d3", 1, 0, 4'd3, mk(2, 0, 0, 0, 0, 3, P0));
    step("reopen_end", 1, 0, 4'd4, mk(3, 1, 0, 0, 0, 0, P0));
    step("chg_enter", 0, 1, 4'd0, mk(4, 1, 0, 0, 0, 0, P0));
    step("chg_d1", 1, 0, 4'd9, mk(4, 1, 0, 0, 0, 1, P0));
    step("chg_d2", 1, 0, 4'd8, mk(4, 1, 0, 0, 0, 2, P0));
    step("chg_d3", 1, 0, 4'd7, mk(4, 1, 0, 0, 0, 3, P0));
    step("chg_commit", 1, 0, 4'd6, mk(3, 1, 0, 0, 0, 0, P1));
    step("chg_close", 1, 0, 4'd0, mk(1, 0, 0, 0, 0, 0, P1));
    step("new_d1", 1, 0, 4'd9, mk(2, 0, 0, 0, 0, 1, P1));
    step("new_d2", 1, 0, 4'd8, mk(2, 0, 0, 0, 0, 2, P1));
    step("new_d3", 1, 0, 4'd7, mk(2, 0, 0, 0, 0, 3, P1));
    step("new_open", 1, 0, 4'd6, mk(3, 1, 0, 0, 0, 0, P1));
    step("new_close", 1, 0, 4'd0, mk(1, 0, 0, 0, 0, 0, P1));
    step("old_d1", 1, 0, 4'd1, mk(2, 0, 0, 0, 0, 1, P1));
    step("old_d2", 1, 0, 4'd2, mk(2, 0, 0, 0, 0, 2, P1));
    step("old_d3", 1, 0, 4'd3, mk(2, 0, 0, 0, 0, 3, P1));
    step("old_rejected", 1, 0, 4'd4, mk(1, 0, 1, 0, 1, 0, P1));
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  task automatic test_vault();
    step("v_d1", 1, 0, 4'd9, mk(2, 0, 0, 0, 1, 1, P1));
    step("v_d2", 1, 0, 4'd8, mk(2, 0, 0, 0, 1, 2, P1));
    @(negedge Clk); vault_open = 1'b0;
    @(posedge Clk); #1;
    sb.push_back(ex("vault_drop_entry", mk(0, 0, 0, 0, 1, 0, P1)));
    respQ.push_back(snap);
    @(negedge Clk); vault_open = 1'b1;
    @(posedge Clk); #1;
    sb.push_back(ex("vault_reopen", mk(1, 0, 0, 0, 1, 0, P1)));
    respQ.push_back(snap);
    step("va_d1", 1, 0, 4'd1, mk(2, 0, 0, 0, 1, 1, P1));
    step("va_d2", 1, 0, 4'd2, mk(2, 0, 0, 0, 1, 2, P1));
    step("va_d3", 1, 0, 4'd3, mk(2, 0, 0, 0, 1, 3, P1));
    step("va_end", 1, 0, 4'd5, mk(1, 0, 1, 0, 2, 0, P1));
    step("vb_d1", 1, 0, 4'd1, mk(2, 0, 0, 0, 2, 1, P1));
    step("vb_d2", 1, 0, 4'd2, mk(2, 0, 0, 0, 2, 2, P1));
    step("vb_d3", 1, 0, 4'd3, mk(2, 0, 0, 0, 2, 3, P1));
    step("vb_lock", 1, 0, 4'd5, mk(5, 0, 1, 1, 3, 0, P1));
    lockCyc = respCyc;
    @(negedge Clk); vault_open = 1'b0;
    @(posedge Clk); #1;
    sb.push_back(ex("vault_drop_lockout", mk(0, 0, 0, 1, 3, 0, P1)));
    respQ.push_back(snap);
    repeat (10) @(negedge Clk);
    vault_open = 1'b1;
    @(posedge Clk); #1;
    sb.push_back(ex("vault_reopen_lockout", mk(5, 0, 0, 1, 3, 0, P1)));
    respQ.push_back(snap);
    waitUnlock();
    sb.push_back(ex("vault_lockout_len", 27'(LCK)));
    respQ.push_back(27'(fallCyc - lockCyc));
    sb.push_back(ex("vault_lockout_exit", 27'({3'd1, 1'b0, 2'd0})));
    respQ.push_back(27'({state, locked, fail_count}));
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  task automatic test_simultaneous();
    step("sim_d1", 1, 0, 4'd9, mk(2, 0, 0, 0, 0, 1, P1));
    step("sim_d2", 1, 0, 4'd8, mk(2, 0, 0, 0, 0, 2, P1));
    step("sim_both_abort", 1, 1, 4'd7, mk(1, 0, 0, 0, 0, 0, P1));
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  task automatic test_reset_newpin();
    step("rn_d1", 1, 0, 4'd9, mk(2, 0, 0, 0, 0, 1, P1));
    step("rn_d2", 1, 0, 4'd8, mk(2, 0, 0, 0, 0, 2, P1));
    step("rn_d3", 1, 0, 4'd7, mk(2, 0, 0, 0, 0, 3, P1));
    step("rn_open", 1, 0, 4'd6, mk(3, 1, 0, 0, 0, 0, P1));
    step("rn_newpin", 0, 1, 4'd0, mk(4, 1, 0, 0, 0, 0, P1));
    step("rn_np_d1", 1, 0, 4'd1, mk(4, 1, 0, 0, 0, 1, P1));
    step("rn_np_d2", 1, 0, 4'd2, mk(4, 1, 0, 0, 0, 2, P1));
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    sb.push_back(ex("async_reset_newpin", mk(0, 0, 0, 0, 0, 0, P0)));
    respQ.push_back(snap);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    sb.push_back(ex("after_reset_closed", mk(1, 0, 0, 0, 0, 0, P0)));
    respQ.push_back(snap);
    while (sb.size() != 0) begin
      e = sb.pop_front(); r = respQ.pop_front(); nRun++;
      if (r !== e.val) begin nFail++; $display("FAIL %s: got %h expected %h", e.tag, r, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_correct_entry();
    test_close_rules();
    test_bounce_lockout();
    test_pin_change();
    test_vault();
    test_simultaneous();
    test_reset_newpin();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", nRun);
    $fatal(1, "time limit");
  end

endmodule
